// File: rtl/spi_mem_if.sv
// Serial link between the SPI master and the memory target.
// Valid/ready semantics: cs low frames the transfer and mosi carries one bit per clock. The target qualifies read data with a one-cycle ready pulse before streaming miso, and acknowledges a consumed write frame with a one-cycle op_done pulse.
interface spi_mem_if;
    logic       cs;
    logic       mosi;
    logic       miso;
    logic       ready;
    logic       op_done;
    logic [3:0] dbg_state;

    modport master (output cs, mosi, input miso, ready, op_done, dbg_state);
    modport slave  (input cs, mosi, output miso, ready, op_done, dbg_state);
endinterface

// File: rtl/spi_mem_slave.sv
// SPI target memory: deserialises LSB-first {op, addr, data} frames into a DEPTH x 8 register file
// and serialises read bytes back on miso behind a one-cycle ready pulse.
module spi_mem_slave #(
    parameter int DEPTH  = 32,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) (
    input logic      clk,
    input logic      rst,
    spi_mem_if.slave bus
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [ADDR_W:0] DEPTH_L = DEPTH[ADDR_W:0];

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        GET_OP    = 4'd1,
        WR_ADDR   = 4'd2,
        RD_ADDR   = 4'd3,
        WR_DATA   = 4'd4,
        WRITE     = 4'd5,
        RD_MEM    = 4'd6,
        SEND_RDY  = 4'd7,
        SEND_DATA = 4'd8
    } state_t;

    state_t              state_q, state_d;
    logic [2:0]          cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [DATA_W-1:0]   rd_byte_q, rd_byte_d;
    logic                miso_q, miso_d;
    logic                ready_q, ready_d;
    logic                op_done_q, op_done_d;
    logic                mem_we;
    logic                in_range;
    logic [DATA_W-1:0]   rd_val;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    assign in_range = ({1'b0, addr_q} < DEPTH_L);
    assign rd_val   = in_range ? mem_q[addr_q[IDX_W-1:0]] : '0;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        data_d    = data_q;
        rd_byte_d = rd_byte_q;
        miso_d    = 1'b0;
        ready_d   = 1'b0;
        op_done_d = 1'b0;
        mem_we    = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!bus.cs) state_d = GET_OP;
            end
            GET_OP: begin
                cnt_d = '0;
                if (bus.cs) state_d = IDLE;
                else        state_d = bus.mosi ? WR_ADDR : RD_ADDR;
            end
            WR_ADDR, RD_ADDR: begin
                if (bus.cs) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    addr_d = {bus.mosi, addr_q[ADDR_W-1:1]};
                    cnt_d  = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) state_d = (state_q == WR_ADDR) ? WR_DATA : RD_MEM;
                end
            end
            WR_DATA: begin
                if (bus.cs) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    data_d = {bus.mosi, data_q[DATA_W-1:1]};
                    cnt_d  = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) state_d = WRITE;
                end
            end
            WRITE: begin
                // Out-of-range writes still complete the handshake; only the store is dropped.
                mem_we    = in_range;
                op_done_d = 1'b1;
                state_d   = IDLE;
            end
            RD_MEM: begin
                rd_byte_d = rd_val;
                ready_d   = 1'b1;
                miso_d    = rd_val[0];
                state_d   = SEND_RDY;
            end
            SEND_RDY: begin
                // Bit 0 is held for a second cycle so the master's first sample edge sees it.
                miso_d  = rd_byte_q[0];
                cnt_d   = '0;
                state_d = SEND_DATA;
            end
            SEND_DATA: begin
                if (cnt_q == 3'd7) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    miso_d = rd_byte_q[cnt_q + 3'd1];
                    cnt_d  = cnt_q + 3'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            rd_byte_q <= '0;
            miso_q    <= 1'b0;
            ready_q   <= 1'b0;
            op_done_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            rd_byte_q <= rd_byte_d;
            miso_q    <= miso_d;
            ready_q   <= ready_d;
            op_done_q <= op_done_d;
            if (mem_we) mem_q[addr_q[IDX_W-1:0]] <= data_q;
        end
    end

    assign bus.miso      = miso_q;
    assign bus.ready     = ready_q;
    assign bus.op_done   = op_done_q;
    assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_spi_mem_slave.sv
// Directed bench for spi_mem_slave: table of write/read frames plus abort and mid-read reset sequences.
module tb_spi_mem_slave;
    logic clk;
    logic rst;
    int   tests;
    int   fails;
    int   overlap;

    spi_mem_if bus();

    spi_mem_slave dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.ready && bus.op_done) overlap++;
    end

    typedef struct {
        logic       is_write;
        logic [7:0] addr;
        logic [7:0] data;
    } vec_t;

    vec_t vecs [12];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) begin
            bus.mosi = b[i];
            tick();
        end
    endtask

    task automatic write_frame(input logic [7:0] addr, input logic [7:0] data);
        bus.cs = 1'b0;
        tick();
        bus.mosi = 1'b1;
        tick();
        send_byte(addr);
        send_byte(data);
        bus.cs = 1'b1;
        check("op_done_early", {31'b0, bus.op_done}, 32'd0);
        tick();
        check("op_done_pulse", {30'b0, bus.op_done, bus.ready}, 32'd2);
        tick();
        check("op_done_width", {31'b0, bus.op_done}, 32'd0);
    endtask

    task automatic read_start(input logic [7:0] addr);
        bus.cs = 1'b0;
        tick();
        bus.mosi = 1'b0;
        tick();
        send_byte(addr);
        bus.cs = 1'b1;
    endtask

    task automatic read_frame(input logic [7:0] addr, input logic [7:0] exp);
        logic [7:0] dout;
        dout = '0;
        read_start(addr);
        check("ready_early", {31'b0, bus.ready}, 32'd0);
        tick();
        check("ready_pulse_miso0", {30'b0, bus.ready, bus.miso}, {30'b0, 1'b1, exp[0]});
        for (int i = 0; i < 8; i++) begin
            tick();
            if (i == 0) check("ready_width", {31'b0, bus.ready}, 32'd0);
            dout[i] = bus.miso;
        end
        check("read_dout", {24'b0, dout}, {24'b0, exp});
        tick();
        check("read_tail_idle", {27'b0, bus.miso, bus.dbg_state}, 32'd0);
    endtask

    initial begin
        logic [7:0] model [32];
        tests   = 0;
        fails   = 0;
        overlap = 0;
        for (int i = 0; i < 32; i++) model[i] = 8'h00;

        vecs[0]  = '{1'b0, 8'd0,  8'h00};
        vecs[1]  = '{1'b1, 8'd3,  8'hA5};
        vecs[2]  = '{1'b0, 8'd3,  8'h00};
        vecs[3]  = '{1'b1, 8'd31, 8'h3C};
        vecs[4]  = '{1'b0, 8'd31, 8'h00};
        vecs[5]  = '{1'b1, 8'd40, 8'hFF};
        vecs[6]  = '{1'b0, 8'd40, 8'h00};
        vecs[7]  = '{1'b0, 8'd8,  8'h00};
        vecs[8]  = '{1'b0, 8'd3,  8'h00};
        vecs[9]  = '{1'b1, 8'd0,  8'h81};
        vecs[10] = '{1'b0, 8'd0,  8'h00};
        vecs[11] = '{1'b0, 8'd31, 8'h00};

        rst      = 1'b1;
        bus.cs   = 1'b1;
        bus.mosi = 1'b0;
        tick();
        tick();
        check("reset_outputs", {25'b0, bus.miso, bus.ready, bus.op_done, bus.dbg_state}, 32'd0);
        rst = 1'b0;
        tick();

        // Expected read data comes from a bench-side shadow of the memory.
        foreach (vecs[k]) begin
            if (vecs[k].is_write) begin
                write_frame(vecs[k].addr, vecs[k].data);
                if (vecs[k].addr < 8'd32) model[vecs[k].addr[4:0]] = vecs[k].data;
            end else begin
                read_frame(vecs[k].addr, (vecs[k].addr < 8'd32) ? model[vecs[k].addr[4:0]] : 8'h00);
            end
        end

        // Abort a write to addr 5 after four address bits.
        write_frame(8'd5, 8'h66);
        bus.cs = 1'b0;
        tick();
        bus.mosi = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            bus.mosi = (i == 0 || i == 2);
            tick();
        end
        bus.cs = 1'b1;
        bus.mosi = 1'b1;
        tick();
        check("abort_idle", {28'b0, bus.dbg_state}, 32'd0);
        begin
            int seen;
            seen = 0;
            for (int i = 0; i < 20; i++) begin
                tick();
                if (bus.op_done) seen++;
            end
            check("abort_no_op_done", seen, 32'd0);
        end
        read_frame(8'd5, 8'h66);

        // Reset in the middle of streaming a read byte.
        read_start(8'd3);
        tick();
        tick();
        tick();
        check("pre_reset_state", {28'b0, bus.dbg_state}, 32'd8);
        rst = 1'b1;
        tick();
        check("mid_reset_outputs", {25'b0, bus.miso, bus.ready, bus.op_done, bus.dbg_state}, 32'd0);
        rst = 1'b0;
        tick();
        read_frame(8'd3, 8'h00);
        read_frame(8'd5, 8'h00);
        write_frame(8'd7, 8'h5A);
        read_frame(8'd7, 8'h5A);

        check("ready_op_done_overlap", overlap, 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/spi_mem_slave.md
Name: spi_mem_slave

Overview:
- SPI target-side memory sitting directly downstream of the team's SPI master controller; consumes cs/mosi and produces miso, ready and op_done.
- Deserializes the master's LSB-first frame: op bit (1 = write, 0 = read), 8-bit address, then 8-bit data on writes.
- Writes an internal 32x8 register file. On reads, it returns the byte on miso behind a one-cycle ready pulse.
- Used as the DUT-side partner in the SPI UVM environment.

Parameters:
DEPTH, 32, number of 8-bit memory words; addresses >= DEPTH are out of range.
DATA_W, 8, data width (fixed frame format; only 8 supported).
ADDR_W, 8, serial address field width (fixed; only 8 supported).

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  reset; synchronous and active-high
cs  input  1  chip select from master, active low
mosi  input  1  serial data from master, LSB first
miso  output  1  serial read data to master, LSB first
ready  output  1  one-cycle pulse: read data about to be shifted out
op_done  output  1  one-cycle pulse: write frame consumed

Behaviour:
- Reset (rst=1 at edge): state=IDLE; miso=0, ready=0, op_done=0; bit counter=0; all DEPTH words cleared to 8'h00. Reset has priority in every state, including mid-frame.
- All outputs are registered. Bit samples are taken at rising edges; E(n) denotes the edge at which cs is first sampled low.
- IDLE: outputs 0. cs==0 at an edge -> GET_OP. No mosi sample at that edge, because the master drives bit0 one cycle after cs falls.
- GET_OP: sample mosi as op bit (edge E(n+1)).
  - op=1 -> WR_ADDR.
  - op=0 -> RD_ADDR.
- WR_ADDR / RD_ADDR: sample 8 address bits LSB first on 8 consecutive edges into addr_reg.
  - WR_ADDR -> WR_DATA.
  - RD_ADDR -> RD_MEM.
- WR_DATA: sample 8 data bits LSB first on 8 consecutive edges. The last bit is at E(n+17). Then -> WRITE.
- WRITE (one cycle):
  - If addr_reg < DEPTH, mem[addr_reg] <= data_reg; otherwise the write is dropped silently.
  - op_done <= 1 for exactly one cycle. -> IDLE.
- RD_MEM (one cycle): rd_byte <= (addr_reg < DEPTH) ? mem[addr_reg] : 8'h00. -> SEND_RDY.
- SEND_RDY: ready=1 for exactly one cycle (cycle R); miso=rd_byte[0] during R. -> SEND_DATA.
- SEND_DATA:
  - miso=rd_byte[0] in cycle R+1.
  - miso=rd_byte[i] in cycle R+1+i, i=1..7.
  - After cycle R+8, miso=0 -> IDLE.
  - This matches a master that detects ready at the end of R and samples miso on the following 8 edges.
- Abort: cs sampled high while in GET_OP, WR_ADDR, WR_DATA or RD_ADDR -> IDLE immediately. Partial frame discarded; no memory write, no ready, no op_done.
- cs is ignored in WRITE, RD_MEM, SEND_RDY and SEND_DATA, because the master releases cs before those phases.
- cs held low on return to IDLE starts a new frame (back-to-back allowed; no dead cycle beyond IDLE's own cycle).
- mosi value is ignored when not in a sampling state.
- Latency:
  - Write: op_done is high in the cycle after edge E(n+18), i.e. 2 edges after the last data bit is sampled.
  - Read: ready is high 2 cycles after the last address bit is sampled (RD_MEM then SEND_RDY).
- ready and op_done are never high simultaneously.

Test Plan:
- Write 8'hA5 to addr 3 (frame bits 1, 8'h03, 8'hA5) -> op_done one cycle exactly 18 edges after E(n) edge count per above; mem[3]=8'hA5; ready stays 0.
- Read addr 3 after that write -> single ready pulse; miso serializes 1,0,1,0,0,1,0,1 (LSB first) over cycles R+1..R+8; master dout=8'hA5.
- Boundary: write 8'h3C to addr 31, then read addr 31 -> 8'h3C. Read addr 0 after reset -> 8'h00.
- Out-of-range: write 8'hFF to addr 40 -> op_done pulses, no word changes. Read addr 40 -> 8'h00 returned with normal ready timing.
- Abort: raise cs after 4 address bits of a write to addr 5 -> no op_done, mem[5] unchanged. The next full read of addr 5 is correct.
- Reset mid-read (rst during SEND_DATA) -> next cycle miso=0, ready=0, state IDLE, memory cleared. A subsequent write/read of addr 7 with 8'h5A succeeds.
